// File: rtl/vga_pkg.sv
// Shared definitions for the VGA timing engine.
//   mode_e    : pixel source select (memory, colour bars, solid colour)
//   align_t   : per-pixel control word carried through the read-latency delay line
//   *_DEF     : 640x480@60 default timing
//   bar_bgr() : colour of bar k (0 = black ... 7 = white), packed {b,g,r}
package vga_pkg;

    localparam int BGR_W = 24;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    typedef enum logic [1:0] {
        MODE_MEM   = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_SOLID = 2'd2
    } mode_e;

    typedef struct packed {
        logic       vis;
        logic       hs;
        logic       vs;
        mode_e      mode;
        logic [2:0] bar;
    } align_t;

    function automatic logic [BGR_W-1:0] bar_bgr(input logic [2:0] k);
        return {{8{k[2]}}, {8{k[1]}}, {8{k[0]}}};
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis (horizontal or vertical).
//   clk, rst : clock, async active-high reset
//   en       : advance the count this cycle
//   count    : current position 0..TOTAL-1
//   active   : count < ACTIVE
//   sync     : ACTIVE+FP <= count < ACTIVE+FP+SYNC
//   wrap     : en is high and count is at TOTAL-1 (next cycle is 0)
// active/sync are registered from the next count so they line up with count.
module vga_axis_counter #(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48,
    parameter int CW     = $clog2(ACTIVE + FP + SYNC + BP)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic          active,
    output logic          sync,
    output logic          wrap
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;
    localparam logic [CW-1:0] LAST     = CW'(TOTAL - 1);
    localparam logic [31:0]   ACT_END  = 32'(ACTIVE);
    localparam logic [31:0]   SYNC_BEG = 32'(ACTIVE + FP);
    localparam logic [31:0]   SYNC_END = 32'(ACTIVE + FP + SYNC);

    logic [CW-1:0] count_q, count_d;
    logic          active_q, active_d;
    logic          sync_q, sync_d;
    logic [31:0]   nxt;

    always_comb begin
        wrap    = en && (count_q == LAST);
        count_d = count_q;
        if (en)
            count_d = wrap ? '0 : count_q + CW'(1);
        // widen so the range tests cannot overflow when a porch is zero
        nxt      = 32'(count_d);
        active_d = nxt < ACT_END;
        sync_d   = (nxt >= SYNC_BEG) && (nxt < SYNC_END);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= '0;
            active_q <= 1'b0;
            sync_q   <= 1'b0;
        end else begin
            count_q  <= count_d;
            active_q <= active_d;
            sync_q   <= sync_d;
        end
    end

    assign count  = count_q;
    assign active = active_q;
    assign sync   = sync_q;

endmodule

// File: rtl/vga_timing_engine.sv
// Parametrised VGA timing engine: sync generation, linear pixel address,
// frame-synchronous source select and output alignment.
//   iVGA_CLK, iRST     : pixel clock, async active-high reset
//   i_mode             : 0 memory, 1 colour bars, 2 solid, 3 = memory
//   i_solid_bgr        : solid colour {b,g,r}
//   i_pix_bgr          : memory pixel, valid RD_LAT clocks after its o_addr
//   o_addr/o_addr_valid: y*H_ACTIVE+x of the current counter state, visible flag
//   o_frame_start      : pulse at counter position (0,0), not delayed
//   oHS/oVS/oBLANK_n/rgb: pins, RD_LAT+1 clocks behind the counter state
module vga_timing_engine
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = H_ACTIVE_DEF,
    parameter int   H_FP     = H_FP_DEF,
    parameter int   H_SYNC   = H_SYNC_DEF,
    parameter int   H_BP     = H_BP_DEF,
    parameter int   V_ACTIVE = V_ACTIVE_DEF,
    parameter int   V_FP     = V_FP_DEF,
    parameter int   V_SYNC   = V_SYNC_DEF,
    parameter int   V_BP     = V_BP_DEF,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   ADDR_W   = 19,
    parameter int   RD_LAT   = 1
) (
    input  logic              iVGA_CLK,
    input  logic              iRST,
    input  logic [1:0]        i_mode,
    input  logic [BGR_W-1:0]  i_solid_bgr,
    input  logic [BGR_W-1:0]  i_pix_bgr,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_addr_valid,
    output logic              o_frame_start,
    output logic              oHS,
    output logic              oVS,
    output logic              oBLANK_n,
    output logic [7:0]        r_data,
    output logic [7:0]        g_data,
    output logic [7:0]        b_data
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int BW      = H_ACTIVE / 8;
    localparam int SW      = (BW > 1) ? $clog2(BW) : 1;
    localparam logic [SW-1:0] SUB_LAST = SW'(BW - 1);

    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic          h_act, h_sync, h_wrap;
    logic          v_act, v_sync, v_wrap;
    logic          vis;

    // run_q holds the counters at (0,0) for the first edge after reset so
    // that (0,0) is the first state presented once reset is released.
    logic              run_q, run_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    mode_e             mode_q, mode_d;
    logic [2:0]        bar_q, bar_d;
    logic [SW-1:0]     sub_q, sub_d;

    align_t                 stage0;
    align_t [RD_LAT-1:0]    pipe_q, pipe_d;
    align_t                 dly;
    logic [BGR_W-1:0]       src;
    logic [BGR_W-1:0]       bgr_q, bgr_d;
    logic                   blank_n_q, blank_n_d;
    logic                   hs_q, hs_d;
    logic                   vs_q, vs_d;

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .CW(HW)
    ) u_h (
        .clk(iVGA_CLK), .rst(iRST), .en(run_q),
        .count(hcnt), .active(h_act), .sync(h_sync), .wrap(h_wrap)
    );

    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .CW(VW)
    ) u_v (
        .clk(iVGA_CLK), .rst(iRST), .en(h_wrap),
        .count(vcnt), .active(v_act), .sync(v_sync), .wrap(v_wrap)
    );

    // v_wrap implies h_wrap: this cycle is (H_TOTAL-1, V_TOTAL-1).
    always_comb begin
        run_d  = 1'b1;
        vis    = h_act & v_act;

        addr_d = addr_q;
        if (v_wrap)
            addr_d = '0;
        else if (vis)
            addr_d = addr_q + ADDR_W'(1);

        mode_d = mode_q;
        if (v_wrap)
            mode_d = (i_mode == 2'd3) ? MODE_MEM : mode_e'(i_mode);

        // bar index = x / (H_ACTIVE/8) without a divider
        bar_d = bar_q;
        sub_d = sub_q;
        if (h_wrap) begin
            bar_d = '0;
            sub_d = '0;
        end else if (h_act) begin
            if (sub_q == SUB_LAST) begin
                sub_d = '0;
                bar_d = bar_q + 3'd1;
            end else begin
                sub_d = sub_q + SW'(1);
            end
        end
    end

    always_ff @(posedge iVGA_CLK or posedge iRST) begin
        if (iRST) begin
            run_q  <= 1'b0;
            addr_q <= '0;
            mode_q <= MODE_MEM;
            bar_q  <= '0;
            sub_q  <= '0;
        end else begin
            run_q  <= run_d;
            addr_q <= addr_d;
            mode_q <= mode_d;
            bar_q  <= bar_d;
            sub_q  <= sub_d;
        end
    end

    // Delay line: control travels alongside the memory read.
    always_comb begin
        stage0      = '0;
        stage0.vis  = vis;
        stage0.hs   = h_sync;
        stage0.vs   = v_sync;
        stage0.mode = mode_q;
        stage0.bar  = bar_q;

        pipe_d    = '0;
        pipe_d[0] = stage0;
        for (int i = 1; i < RD_LAT; i++)
            pipe_d[i] = pipe_q[i-1];
    end

    // Output register samples i_pix_bgr exactly RD_LAT clocks after its address.
    always_comb begin
        dly = pipe_q[RD_LAT-1];
        case (dly.mode)
            MODE_BARS:  src = bar_bgr(dly.bar);
            MODE_SOLID: src = i_solid_bgr;
            default:    src = i_pix_bgr;
        endcase
        bgr_d     = dly.vis ? src : '0;
        blank_n_d = dly.vis;
        hs_d      = dly.hs ? HS_POL : ~HS_POL;
        vs_d      = dly.vs ? VS_POL : ~VS_POL;
    end

    always_ff @(posedge iVGA_CLK or posedge iRST) begin
        if (iRST) begin
            pipe_q    <= '0;
            bgr_q     <= '0;
            blank_n_q <= 1'b0;
            hs_q      <= ~HS_POL;
            vs_q      <= ~VS_POL;
        end else begin
            pipe_q    <= pipe_d;
            bgr_q     <= bgr_d;
            blank_n_q <= blank_n_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
        end
    end

    assign o_addr        = addr_q;
    assign o_addr_valid  = vis;
    assign o_frame_start = run_q && (hcnt == '0) && (vcnt == '0);
    assign oHS           = hs_q;
    assign oVS           = vs_q;
    assign oBLANK_n      = blank_n_q;
    assign b_data        = bgr_q[23:16];
    assign g_data        = bgr_q[15:8];
    assign r_data        = bgr_q[7:0];

endmodule

// File: tb/tb_vga_timing_engine.sv
// Directed bench for vga_timing_engine with a 15x8 total / 8x4 visible raster
// and RD_LAT = 2. Memory is emulated as i_pix_bgr = {b=5A, g=00, r=addr}
// delayed by two clocks, so pins show {r,g,b} = {addr, 00, 5A}.
// Cycle k counts clock periods after reset release; k = 0 is counter state (0,0).
module tb_vga_timing_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  i_mode = 2'd0;
    logic [23:0] i_solid_bgr = 24'h0;
    logic [23:0] i_pix_bgr;
    logic [5:0]  o_addr;
    logic        o_addr_valid, o_frame_start, oHS, oVS, oBLANK_n;
    logic [7:0]  r_data, g_data, b_data;
    logic [5:0]  a1 = 6'd0, a2 = 6'd0;

    int checks = 0;
    int failures = 0;
    int cyc = -1;

    always #5 clk = ~clk;

    vga_timing_engine #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .ADDR_W(6), .RD_LAT(2)
    ) dut (
        .iVGA_CLK(clk), .iRST(rst), .i_mode(i_mode),
        .i_solid_bgr(i_solid_bgr), .i_pix_bgr(i_pix_bgr),
        .o_addr(o_addr), .o_addr_valid(o_addr_valid), .o_frame_start(o_frame_start),
        .oHS(oHS), .oVS(oVS), .oBLANK_n(oBLANK_n),
        .r_data(r_data), .g_data(g_data), .b_data(b_data)
    );

    // two-clock read latency memory
    always @(posedge clk) begin
        a1 <= o_addr;
        a2 <= a1;
    end
    assign i_pix_bgr = {8'h5A, 8'h00, 2'b00, a2};

    typedef struct {
        int          k;
        logic [5:0]  addr;
        logic        v, fs, bl, hs, vs;
        logic [23:0] rgb;
    } vec_t;
    vec_t vq[$];

    task automatic add(int k, logic [5:0] addr, logic v, logic fs, logic bl,
                       logic hs, logic vs, logic [23:0] rgb);
        vec_t e;
        e.k = k; e.addr = addr; e.v = v; e.fs = fs; e.bl = bl;
        e.hs = hs; e.vs = vs; e.rgb = rgb;
        vq.push_back(e);
    endtask

    function automatic logic [34:0] outs();
        return {o_addr, o_addr_valid, o_frame_start, oBLANK_n, oHS, oVS,
                r_data, g_data, b_data};
    endfunction

    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (k=%0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic tick_to(int k);
        while (cyc < k) tick();
    endtask

    logic [23:0] bar_exp [15];

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_bl, n_hs, n_vs, n_fs, last_fs, exp_r, bad;

        //    k    addr v  fs bl hs vs rgb{r,g,b}
        add(  0,  0, 1, 1, 0, 1, 1, 24'h000000);
        add(  3,  3, 1, 0, 1, 1, 1, 24'h00005A);
        add(  7,  7, 1, 0, 1, 1, 1, 24'h04005A);
        add(  8,  8, 0, 0, 1, 1, 1, 24'h05005A);
        add( 10,  8, 0, 0, 1, 1, 1, 24'h07005A);
        add( 11,  8, 0, 0, 0, 1, 1, 24'h000000);
        add( 13,  8, 0, 0, 0, 0, 1, 24'h000000);
        add( 15,  8, 1, 0, 0, 0, 1, 24'h000000);
        add( 16,  9, 1, 0, 0, 1, 1, 24'h000000);
        add( 18, 11, 1, 0, 1, 1, 1, 24'h08005A);
        add( 48, 27, 1, 0, 1, 1, 1, 24'h18005A);
        add( 55, 32, 0, 0, 1, 1, 1, 24'h1F005A);
        add( 60, 32, 0, 0, 0, 0, 1, 24'h000000);
        add( 77, 32, 0, 0, 0, 1, 1, 24'h000000);
        add( 78, 32, 0, 0, 0, 1, 0, 24'h000000);
        add(107, 32, 0, 0, 0, 1, 0, 24'h000000);
        add(108, 32, 0, 0, 0, 1, 1, 24'h000000);
        add(119, 32, 0, 0, 0, 0, 1, 24'h000000);
        add(120,  0, 1, 1, 0, 0, 1, 24'h000000);
        add(123,  3, 1, 0, 1, 1, 1, 24'h00005A);

        bar_exp = '{24'h000000, 24'hFF0000, 24'h00FF00, 24'hFFFF00,
                    24'h0000FF, 24'hFF00FF, 24'h00FFFF, 24'hFFFFFF,
                    24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0};

        repeat (3) @(negedge clk);
        check("reset_state", 64'(outs()), 64'({6'd0, 5'b00011, 24'h0}));
        rst = 1'b0;

        foreach (vq[i]) begin
            tick_to(vq[i].k);
            check($sformatf("vec%0d", i), 64'(outs()),
                  64'({vq[i].addr, vq[i].v, vq[i].fs, vq[i].bl, vq[i].hs,
                       vq[i].vs, vq[i].rgb}));
        end

        // full frame 1 on the pins: k = 123..242
        n_bl = 0; n_hs = 0; n_vs = 0; n_fs = 0; last_fs = -1; exp_r = 0; bad = 0;
        for (int n = 0; n < 120; n++) begin
            if (n > 0) tick();
            if (oBLANK_n) begin
                n_bl++;
                if ({r_data, g_data, b_data} !== {8'(exp_r), 8'h00, 8'h5A}) bad++;
                exp_r++;
            end else if ({r_data, g_data, b_data} !== 24'h0) begin
                bad++;
            end
            if (!oHS) n_hs++;
            if (!oVS) n_vs++;
            if (o_frame_start) begin n_fs++; last_fs = cyc; end
        end
        check("frame_blank_n_high", 64'(n_bl), 64'd32);
        check("frame_hs_low", 64'(n_hs), 64'd24);
        check("frame_vs_low", 64'(n_vs), 64'd30);
        check("frame_start_count", 64'(n_fs), 64'd1);
        check("frame_start_cycle", 64'(last_fs), 64'd240);
        check("frame_pixel_order", 64'(bad), 64'd0);

        // mid-frame switch to solid: current frame stays memory
        tick_to(250);
        i_mode = 2'd2;
        i_solid_bgr = 24'h123456;
        tick_to(290);
        check("mid_switch_mem", 64'({oBLANK_n, r_data, g_data, b_data}), 64'({1'b1, 24'h1A005A}));
        tick_to(363);
        check("solid_px0", 64'({oBLANK_n, r_data, g_data, b_data}), 64'({1'b1, 24'h563412}));
        tick_to(364);
        check("solid_px1", 64'({oBLANK_n, r_data, g_data, b_data}), 64'({1'b1, 24'h563412}));
        tick_to(371);
        check("solid_blank", 64'({oBLANK_n, r_data, g_data, b_data}), 64'({1'b0, 24'h0}));

        // colour bars from frame 4 (pins from k = 483)
        i_mode = 2'd1;
        tick_to(483);
        for (int x = 0; x < 15; x++) begin
            if (x > 0) tick();
            check($sformatf("bars_x%0d", x), 64'({oBLANK_n, r_data, g_data, b_data}),
                  64'({(x < 8) ? 1'b1 : 1'b0, bar_exp[x]}));
        end
        bad = 0; n_bl = 0;
        for (int n = 0; n < 105; n++) begin
            tick();
            if (oBLANK_n) begin
                n_bl++;
                if ({r_data, g_data, b_data} !== bar_exp[(cyc - 483) % 15]) bad++;
            end else if ({r_data, g_data, b_data} !== 24'h0) begin
                bad++;
            end
        end
        check("bars_frame_rgb", 64'(bad), 64'd0);
        check("bars_frame_blank_n", 64'(n_bl), 64'd24);

        // reset mid line 2 of frame 5
        tick_to(635);
        rst = 1'b1;
        #1;
        check("mid_reset_async", 64'(outs()), 64'({6'd0, 5'b00011, 24'h0}));
        @(posedge clk);
        @(negedge clk);
        check("mid_reset_hold", 64'(outs()), 64'({6'd0, 5'b00011, 24'h0}));
        rst = 1'b0;
        cyc = -1;
        tick();
        check("post_reset_k0", 64'(outs()), 64'({6'd0, 5'b11011, 24'h0}));
        tick_to(3);
        check("post_reset_k3_mem", 64'(outs()), 64'({6'd3, 5'b10111, 24'h00005A}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
